// File: rtl/debounce_scan_ctrl.sv
// Round-robin debounce controller: one shared prescaler services one channel per tick.
// Define DBSCAN_STICKY_IRQ_EN to add the sticky o_irq / i_irq_clr pair.
module debounce_scan_ctrl #(
  parameter  int N_CH        = 4,
  parameter  int SYNC_STAGES = 2,
  parameter  int PRESCALE_L2 = 8,
  parameter  int CNT_L2      = 4,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_din,
  output logic [N_CH-1:0] o_state,
  output logic            o_evt_valid,
  output logic [CH_W-1:0] o_evt_ch,
  output logic            o_evt_rise,
  input  logic            i_evt_ready
`ifdef DBSCAN_STICKY_IRQ_EN
  ,
  output logic            o_irq,
  input  logic            i_irq_clr
`endif
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  logic [N_CH-1:0]        sync_q [SYNC_STAGES];
  logic [N_CH-1:0]        s;
  logic [PRESCALE_L2-1:0] presc_q;
  logic                   tick;

  logic [CH_W-1:0]        ptr_q, ptr_d;
  logic [CNT_L2-1:0]      cnt_q [N_CH];
  logic [CNT_L2-1:0]      cnt_d [N_CH];
  logic [N_CH-1:0]        state_q, state_d;

  logic                   evt_valid_q;
  logic [CH_W-1:0]        evt_ch_q;
  logic                   evt_rise_q;

  logic s_cur, mismatch, cnt_full, flip, stall, advance, load;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= i_din;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) presc_q <= '0;
    else          presc_q <= presc_q + 1'b1;
  end

  assign tick = &presc_q;

  assign s_cur    = s[ptr_q];
  assign mismatch = s_cur ^ state_q[ptr_q];
  assign cnt_full = &cnt_q[ptr_q];
  assign flip     = tick & mismatch & cnt_full;
  // A flip that cannot be reported freezes the scan so the same channel retries next tick.
  assign stall    = flip & evt_valid_q & ~i_evt_ready;
  assign advance  = tick & ~stall;
  assign load     = flip & ~stall;

  assign ptr_d = !advance            ? ptr_q :
                 (ptr_q == LAST_CH)  ? '0    : ptr_q + 1'b1;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic sel;
    assign sel          = advance && (ptr_q == CH_W'(gi));
    assign cnt_d[gi]    = !sel                   ? cnt_q[gi] :
                          (mismatch && !cnt_full) ? cnt_q[gi] + 1'b1 : '0;
    assign state_d[gi]  = (sel && flip) ? s_cur : state_q[gi];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q   <= '0;
      state_q <= '0;
      for (int k = 0; k < N_CH; k++) cnt_q[k] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      state_q <= state_d;
      for (int k = 0; k < N_CH; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  // One-deep event slot; a load in the handshake cycle replaces it without a bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_rise_q  <= 1'b0;
    end else if (load) begin
      evt_valid_q <= 1'b1;
      evt_ch_q    <= ptr_q;
      evt_rise_q  <= s_cur;
    end else if (i_evt_ready) begin
      evt_valid_q <= 1'b0;
    end
  end

  assign o_state     = state_q;
  assign o_evt_valid = evt_valid_q;
  assign o_evt_ch    = evt_ch_q;
  assign o_evt_rise  = evt_rise_q;

`ifdef DBSCAN_STICKY_IRQ_EN
  logic irq_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       irq_q <= 1'b0;
    else if (load)      irq_q <= 1'b1;
    else if (i_irq_clr) irq_q <= 1'b0;
  end

  assign o_irq = irq_q;
`endif

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Scoreboard bench for debounce_scan_ctrl: a 4-channel and a 3-channel instance,
// expected events queued by the stimulus and popped by per-instance monitors.
module tb_debounce_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] din4 = '0;
  logic [3:0] state4;
  logic       valid4, rise4;
  logic       ready4 = 1'b1;
  logic [1:0] ch4;

  logic [2:0] din3 = '0;
  logic [2:0] state3;
  logic       valid3, rise3;
  logic       ready3 = 1'b1;
  logic [1:0] ch3;

`ifdef DBSCAN_STICKY_IRQ_EN
  logic irq4, irq3;
  logic irq_clr4 = 1'b0;
  logic irq_clr3 = 1'b0;
`endif

  debounce_scan_ctrl #(.N_CH(4), .SYNC_STAGES(2), .PRESCALE_L2(2), .CNT_L2(2)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_din(din4), .o_state(state4),
    .o_evt_valid(valid4), .o_evt_ch(ch4), .o_evt_rise(rise4), .i_evt_ready(ready4)
`ifdef DBSCAN_STICKY_IRQ_EN
    , .o_irq(irq4), .i_irq_clr(irq_clr4)
`endif
  );

  debounce_scan_ctrl #(.N_CH(3), .SYNC_STAGES(2), .PRESCALE_L2(2), .CNT_L2(2)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_din(din3), .o_state(state3),
    .o_evt_valid(valid3), .o_evt_ch(ch3), .o_evt_rise(rise3), .i_evt_ready(ready3)
`ifdef DBSCAN_STICKY_IRQ_EN
    , .o_irq(irq3), .i_irq_clr(irq_clr3)
`endif
  );

  typedef struct packed {
    logic [1:0] ch;
    logic       rise;
  } evt_t;

  evt_t q4[$];
  evt_t q3[$];
  evt_t e4, e3;
  int   total = 0;
  int   bad   = 0;
  int   seen4 = 0;
  int   seen3 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && valid4 && ready4) begin
      seen4++;
      $display("dut4 event ch=%0d rise=%0d at %0t", ch4, rise4, $time);
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut4_unexpected_evt: got ch=%0d rise=%0d expected none", ch4, rise4);
      end else begin
        e4 = q4.pop_front();
        check("dut4_evt_ch", 32'(ch4), 32'(e4.ch));
        check("dut4_evt_rise", 32'(rise4), 32'(e4.rise));
`ifdef DBSCAN_STICKY_IRQ_EN
        check("dut4_irq_on_evt", 32'(irq4), 32'd1);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && valid3 && ready3) begin
      seen3++;
      $display("dut3 event ch=%0d rise=%0d at %0t", ch3, rise3, $time);
      if (q3.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut3_unexpected_evt: got ch=%0d rise=%0d expected none", ch3, rise3);
      end else begin
        e3 = q3.pop_front();
        check("dut3_evt_ch", 32'(ch3), 32'(e3.ch));
        check("dut3_evt_rise", 32'(rise3), 32'(e3.rise));
      end
    end
  end

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain4(input int max_clk, input string name);
    int n = 0;
    while (q4.size() != 0 && n < max_clk) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 32'(q4.size()), 32'd0);
  endtask

  task automatic wait_drain3(input int max_clk, input string name);
    int n = 0;
    while (q3.size() != 0 && n < max_clk) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 32'(q3.size()), 32'd0);
  endtask

  initial begin
    int n;
    // Reset with all inputs high: everything reads zero.
    rst_n = 1'b0;
    din4  = 4'hF;
    clocks(3);
    check("rst_state4", 32'(state4), 32'd0);
    check("rst_valid4", 32'(valid4), 32'd0);
    check("rst_ch4",    32'(ch4),    32'd0);
    check("rst_rise4",  32'(rise4),  32'd0);
    check("rst_valid3", 32'(valid3), 32'd0);

    // Release; ticks land on edges 4, 8, 12, ... Scan order on the 3-channel build wraps.
    @(negedge clk);
    rst_n = 1'b1;
    clocks(2);
    check("ptr3_seq0", 32'(dut3.ptr_q), 32'd0);
    clocks(4);
    check("ptr3_seq1", 32'(dut3.ptr_q), 32'd1);
    clocks(4);
    check("ptr3_seq2", 32'(dut3.ptr_q), 32'd2);
    clocks(4);
    check("ptr3_seq3", 32'(dut3.ptr_q), 32'd0);

    // Edge 40: ch0 visited at 4,20,36 -> 3; ch3 visited at 16,32 -> 2. Reset mid-count.
    clocks(26);
    check("midcount_cnt0", 32'(dut4.cnt_q[0]), 32'd3);
    check("midcount_cnt3", 32'(dut4.cnt_q[3]), 32'd2);
    rst_n = 1'b0;
    din4  = 4'h0;
    #1;
    check("rst_cnt0", 32'(dut4.cnt_q[0]), 32'd0);
    clocks(2);
    @(negedge clk);
    rst_n = 1'b1;
    clocks(60);
    check("no_evt_after_rst", 32'(seen4), 32'd0);
    check("state_after_rst", 32'(state4), 32'd0);

    // Press on ch2.
    q4.push_back('{ch: 2'd2, rise: 1'b1});
    din4[2] = 1'b1;
    wait_drain4(150, "press_timeout");
    clocks(2);
    check("press_state", 32'(state4), 32'b0100);
    check("press_evt_count", 32'(seen4), 32'd1);

    // Short glitch on ch1.
    din4[1] = 1'b1;
    clocks(3);
    din4[1] = 1'b0;
    clocks(40);
    check("glitch_cnt1", 32'(dut4.cnt_q[1]), 32'd0);
    check("glitch_state", 32'(state4), 32'b0100);
    check("glitch_evt_count", 32'(seen4), 32'd1);

    // Backpressure: ch0 rises, ch3 rises one visit period later so ch0 flips first.
    ready4 = 1'b0;
    q4.push_back('{ch: 2'd0, rise: 1'b1});
    q4.push_back('{ch: 2'd3, rise: 1'b1});
    din4[0] = 1'b1;
    clocks(20);
    din4[3] = 1'b1;
    n = 0;
    while (!valid4 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("bp_valid_seen", 32'(valid4), 32'd1);
    clocks(100);
    check("bp_hold_valid", 32'(valid4), 32'd1);
    check("bp_hold_ch",    32'(ch4),    32'd0);
    check("bp_hold_rise",  32'(rise4),  32'd1);
    check("bp_ptr_stall",  32'(dut4.ptr_q), 32'd3);
    check("bp_state",      32'(state4), 32'b0101);
    check("bp_queue",      32'(q4.size()), 32'd2);
    ready4 = 1'b1;
    wait_drain4(100, "bp_drain_timeout");
    clocks(2);
    check("bp_final_state", 32'(state4), 32'b1101);
    check("bp_evt_count", 32'(seen4), 32'd3);

    // 3-channel build: ch2 rise then fall.
    q3.push_back('{ch: 2'd2, rise: 1'b1});
    din3[2] = 1'b1;
    wait_drain3(150, "wrap_rise_timeout");
    clocks(2);
    check("wrap_rise_state", 32'(state3), 32'b100);
    q3.push_back('{ch: 2'd2, rise: 1'b0});
    din3[2] = 1'b0;
    wait_drain3(150, "wrap_fall_timeout");
    clocks(2);
    check("wrap_fall_state", 32'(state3), 32'b000);
    check("wrap_evt_count", 32'(seen3), 32'd2);

`ifdef DBSCAN_STICKY_IRQ_EN
    check("irq_sticky", 32'(irq4), 32'd1);
    irq_clr4 = 1'b1;
    clocks(1);
    irq_clr4 = 1'b0;
    check("irq_cleared", 32'(irq4), 32'd0);
    irq_clr4 = 1'b1;
`endif
    // Release of ch2; with the IRQ build, clear is held across the event load.
    q4.push_back('{ch: 2'd2, rise: 1'b0});
    din4[2] = 1'b0;
    wait_drain4(150, "release_timeout");
    clocks(2);
    check("release_state", 32'(state4), 32'b1001);
`ifdef DBSCAN_STICKY_IRQ_EN
    check("irq_clr_after_load", 32'(irq4), 32'd0);
    irq_clr4 = 1'b0;
`endif
    check("final_evt_count", 32'(seen4), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
